mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single backing-memory block port between two cache controllers (I-side requester 0, D-side requester 1). It accepts block read (refill) and block write (writeback) requests, grants one at a time with round-robin fairness, drives the memory port until `mem_ack`, and returns completion, read data and a timeout error to the granted requester. It sits between the cache controllers' `mem_*` ports and the memory model.

## Interface
- `PA_WIDTH`, 32, physical address width
- `BLK_WIDTH`, 512, block width in bits (64 B block)
- `TIMEOUT`, 256, max cycles waiting for `mem_ack` before abort (≥2)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req0_rd`, `req1_rd`  in  1  block read request, level, held until done
- `req0_wr`, `req1_wr`  in  1  block write request, level, held until done
- `req0_addr`, `req1_addr`  in  PA_WIDTH  block address
- `req0_wr_blk`, `req1_wr_blk`  in  BLK_WIDTH  writeback data
- `req0_rd_blk`, `req1_rd_blk`  out  BLK_WIDTH  refill data, valid while `reqN_done`
- `req0_done`, `req1_done`  out  1  one-cycle completion pulse
- `req0_err`, `req1_err`  out  1  one-cycle timeout pulse, coincident with `reqN_done`
- `mem_addr`  out  PA_WIDTH  memory address
- `mem_rd_en`  out  1  memory read strobe, level for whole access
- `mem_wr_en`  out  1  memory write strobe, level for whole access
- `mem_wr_blk`  out  BLK_WIDTH  memory write data
- `mem_rd_blk`  in  BLK_WIDTH  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, one cycle

## Operation
- State machine: IDLE, ACCESS, RESP.
- IDLE: request N pending if `reqN_rd | reqN_wr`. None → stay. One → grant it. Both → grant the one not in `last_grant`. Grant registers `gnt`, `last_grant <= gnt`, latches addr/wr_blk/op, clears timeout counter, → ACCESS.
- Op: `reqN_wr` wins if both rd and wr asserted by the same requester; rd is ignored for that transaction (requester re-asserts later).
- ACCESS: `mem_addr`, `mem_wr_blk` from latched values; `mem_wr_en`=op is write, `mem_rd_en`=op is read, never both. Counter increments each cycle.
  - `mem_ack` → capture `mem_rd_blk` (reads), → RESP with err=0.
  - no ack and counter = TIMEOUT-1 → RESP with err=1, rd_blk captured as 0.
- RESP: `mem_rd_en`=`mem_wr_en`=0; `reqgnt_done`=1, `reqgnt_err`=err, `reqgnt_rd_blk`=captured data; → IDLE.
- Requester contract: deassert request on the edge ending its done cycle; request still high in the following IDLE cycle is a new request.
- `mem_ack` in IDLE or RESP ignored. Ungranted requester's outputs stay 0.
- Counter width `$clog2(TIMEOUT)`; never wraps (saturates via exit).

## Timing
- All outputs registered. Reset (cycle after `rst` high): state IDLE, `last_grant`=1 (requester 0 wins first tie), counter 0, every output 0.
- `rst` mid-ACCESS/RESP: abort, no done/err, memory strobes 0 next cycle.
- Request sampled in IDLE at cycle T → `mem_*_en` high from T+1.
- `mem_ack` at cycle M → strobes low and `done` high at M+1 → IDLE at M+2; next grant strobes at M+3 earliest.
- Ack in the first ACCESS cycle allowed (min transaction 3 cycles, T to done).
- Timeout: strobes high exactly TIMEOUT cycles, done+err next cycle.
- Back-to-back contention alternates grants 0,1,0,1.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, no strobes.
- req0_rd addr 0x0000_1000, ack 4 cycles after strobe with data 0xA5..A5 → mem_rd_en 4 cycles, req0_done 1 cycle with req0_rd_blk=0xA5..A5, req1 outputs 0.
- req0_rd and req1_wr asserted same cycle, both held continuously re-asserted → grant order 0,1,0,1; mem_wr_en only during req1 transactions with mem_wr_blk=req1_wr_blk.
- req1_rd and req1_wr together addr 0x40 → only mem_wr_en, done once.
- TIMEOUT=8, no ack → mem_rd_en exactly 8 cycles, req0_done and req0_err together, rd_blk 0, next request granted normally.
- rst high mid-ACCESS, then ack arrives → no done, strobes 0, next grant prefers requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block memory port
// between the I-side (0) and D-side (1) cache controllers.
module mem_arbiter #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_rd,
  input  logic                 req1_rd,
  input  logic                 req0_wr,
  input  logic                 req1_wr,
  input  logic [PA_WIDTH-1:0]  req0_addr,
  input  logic [PA_WIDTH-1:0]  req1_addr,
  input  logic [BLK_WIDTH-1:0] req0_wr_blk,
  input  logic [BLK_WIDTH-1:0] req1_wr_blk,
  output logic [BLK_WIDTH-1:0] req0_rd_blk,
  output logic [BLK_WIDTH-1:0] req1_rd_blk,
  output logic                 req0_done,
  output logic                 req1_done,
  output logic                 req0_err,
  output logic                 req1_err,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_blk,
  input  logic [BLK_WIDTH-1:0] mem_rd_blk,
  input  logic                 mem_ack
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PA_WIDTH-1:0]  addr_q, addr_d;
  logic [BLK_WIDTH-1:0] wr_blk_q, wr_blk_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 err0_q, err0_d;
  logic                 err1_q, err1_d;
  logic [BLK_WIDTH-1:0] rd_blk0_q, rd_blk0_d;
  logic [BLK_WIDTH-1:0] rd_blk1_q, rd_blk1_d;

  logic                 pend0, pend1;
  logic                 pick, pick_wr;
  logic                 fin, fin_err;
  logic [BLK_WIDTH-1:0] fin_blk;

  // gnt_q doubles as last-grant: it keeps the previous winner in IDLE
  always_comb begin
    pend0   = req0_rd | req0_wr;
    pend1   = req1_rd | req1_wr;
    pick    = (pend0 & pend1) ? ~gnt_q : pend1;
    pick_wr = pick ? req1_wr : req0_wr;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_blk_d  = wr_blk_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rd_blk0_d = '0;
    rd_blk1_d = '0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_blk   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pend0 | pend1) begin
          gnt_d    = pick;
          addr_d   = pick ? req1_addr : req0_addr;
          wr_blk_d = pick ? req1_wr_blk : req0_wr_blk;
          wr_en_d  = pick_wr;
          rd_en_d  = ~pick_wr;
          cnt_d    = '0;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          fin     = 1'b1;
          fin_blk = rd_en_q ? mem_rd_blk : '0;
        end else if (cnt_q == CNT_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (fin) begin
          state_d   = S_RESP;
          rd_en_d   = 1'b0;
          wr_en_d   = 1'b0;
          done0_d   = ~gnt_q;
          done1_d   = gnt_q;
          err0_d    = fin_err & ~gnt_q;
          err1_d    = fin_err & gnt_q;
          rd_blk0_d = gnt_q ? '0 : fin_blk;
          rd_blk1_d = gnt_q ? fin_blk : '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b1;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_blk_q  <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rd_blk0_q <= '0;
      rd_blk1_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_blk_q  <= wr_blk_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rd_blk0_q <= rd_blk0_d;
      rd_blk1_q <= rd_blk1_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_blk  = wr_blk_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_err    = err0_q;
  assign req1_err    = err1_q;
  assign req0_rd_blk = rd_blk0_q;
  assign req1_rd_blk = rd_blk1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter
// with a transaction-level round-robin model and memory responder.
module tb_mem_arbiter;

  localparam int PAW = 32;
  localparam int BW  = 512;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_rd = 1'b0, req1_rd = 1'b0;
  logic           req0_wr = 1'b0, req1_wr = 1'b0;
  logic [PAW-1:0] req0_addr = '0, req1_addr = '0;
  logic [BW-1:0]  req0_wr_blk = '0, req1_wr_blk = '0;
  logic [BW-1:0]  req0_rd_blk, req1_rd_blk;
  logic           req0_done, req1_done;
  logic           req0_err, req1_err;
  logic [PAW-1:0] mem_addr;
  logic           mem_rd_en, mem_wr_en;
  logic [BW-1:0]  mem_wr_blk;
  logic [BW-1:0]  mem_rd_blk = '0;
  logic           mem_ack = 1'b0;

  mem_arbiter #(
    .PA_WIDTH (PAW),
    .BLK_WIDTH(BW),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_rd    (req0_rd),
    .req1_rd    (req1_rd),
    .req0_wr    (req0_wr),
    .req1_wr    (req1_wr),
    .req0_addr  (req0_addr),
    .req1_addr  (req1_addr),
    .req0_wr_blk(req0_wr_blk),
    .req1_wr_blk(req1_wr_blk),
    .req0_rd_blk(req0_rd_blk),
    .req1_rd_blk(req1_rd_blk),
    .req0_done  (req0_done),
    .req1_done  (req1_done),
    .req0_err   (req0_err),
    .req1_err   (req1_err),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_blk (mem_wr_blk),
    .mem_rd_blk (mem_rd_blk),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [31:0]   addr;
    logic [BW-1:0] blk;
  } job_t;

  typedef struct {
    bit            wr;
    logic [31:0]   addr;
    logic [BW-1:0] wblk;
    int            lat;
  } acc_t;

  typedef struct {
    int            who;
    bit            err;
    bit            chk;
    logic [BW-1:0] rblk;
  } rsp_t;

  job_t jobs0[$], jobs1[$];
  job_t b0[$], b1[$];
  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int   lat_q[$];
  int   force_lat[$];
  int   model_last = 1;
  int   start_cnt = 0;
  int   inject_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act,
                     input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [BW-1:0] mem_data(input logic [31:0] a);
    logic [BW-1:0] d;
    if (a == 32'h1000) begin
      d = {64{8'hA5}};
    end else begin
      for (int i = 0; i < 16; i++)
        d[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
    end
    return d;
  endfunction

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic job_t mk_job(input int who, input int op,
                                  input logic [31:0] a);
    job_t j;
    j.rd   = (op != 2);
    j.wr   = (op >= 2);
    j.addr = a;
    j.blk  = rnd_blk();
    return j;
  endfunction

  function automatic job_t rnd_job(input int who);
    logic [31:0] a;
    a = (32'($urandom) & 32'h0FFF_FFC0) | (who != 0 ? 32'h8000_0000 : 32'h0);
    return mk_job(who, $urandom_range(0, 3), a);
  endfunction

  // Requester drivers: hold a request until its done, then present the next
  function automatic void drive0();
    if (jobs0.size() != 0) begin
      req0_rd = jobs0[0].rd;
      req0_wr = jobs0[0].wr;
      req0_addr = jobs0[0].addr;
      req0_wr_blk = jobs0[0].blk;
    end else begin
      req0_rd = 1'b0;
      req0_wr = 1'b0;
    end
  endfunction

  function automatic void drive1();
    if (jobs1.size() != 0) begin
      req1_rd = jobs1[0].rd;
      req1_wr = jobs1[0].wr;
      req1_addr = jobs1[0].addr;
      req1_wr_blk = jobs1[0].blk;
    end else begin
      req1_rd = 1'b0;
      req1_wr = 1'b0;
    end
  endfunction

  int st_seen = 0;
  always @(negedge clk) begin
    if (start_cnt != st_seen) begin
      st_seen = start_cnt;
      drive0();
      drive1();
    end else begin
      if (req0_done && jobs0.size() != 0) begin
        void'(jobs0.pop_front());
        drive0();
      end
      if (req1_done && jobs1.size() != 0) begin
        void'(jobs1.pop_front());
        drive1();
      end
    end
  end

  // Memory model: acks after the planned number of strobe cycles
  bit in_r = 0;
  int idx = 0, cur_lat = -1, inj_seen = 0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (inject_cnt != inj_seen) begin
      inj_seen = inject_cnt;
      mem_ack = 1'b1;
    end
    if (mem_rd_en || mem_wr_en) begin
      if (!in_r) begin
        in_r = 1;
        idx = 0;
        cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
      end else begin
        idx++;
      end
      if (idx == cur_lat) begin
        mem_ack = 1'b1;
        mem_rd_blk = mem_data(mem_addr);
      end
    end else begin
      in_r = 0;
    end
  end

  // Monitor: checks memory-port accesses and responses against the queues
  bit in_m = 0;
  int dur = 0;
  acc_t cur;
  rsp_t r;
  always @(negedge clk) begin
    if (rst) begin
      in_m = 0;
    end else begin
      if (mem_rd_en || mem_wr_en) begin
        if (!in_m) begin
          in_m = 1;
          dur = 1;
          if (exp_acc.size() == 0) begin
            chk("unexpected_access", BW'({mem_wr_en, mem_rd_en}), BW'(0));
          end else begin
            cur = exp_acc.pop_front();
            chk("acc_addr", BW'(mem_addr), BW'(cur.addr));
            chk("acc_op", BW'({mem_wr_en, mem_rd_en}),
                BW'(cur.wr ? 2'b10 : 2'b01));
            if (cur.wr) chk("acc_wblk", mem_wr_blk, cur.wblk);
          end
        end else begin
          dur++;
          chk("strobe_hold", BW'({mem_wr_en, mem_rd_en}),
              BW'(cur.wr ? 2'b10 : 2'b01));
        end
      end else if (in_m) begin
        in_m = 0;
        chk("strobe_cycles", BW'(dur),
            BW'(cur.lat < 0 ? TO : cur.lat + 1));
        chk("done_after_strobe", BW'(req0_done | req1_done), BW'(1));
      end
      if (req0_done || req1_done) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_done", BW'({req1_done, req0_done}), BW'(0));
        end else begin
          r = exp_rsp.pop_front();
          chk("done_who", BW'({req1_done, req0_done}),
              BW'(r.who != 0 ? 2'b10 : 2'b01));
          chk("err", BW'({req1_err, req0_err}),
              BW'(r.err ? (r.who != 0 ? 2 : 1) : 0));
          if (r.who == 0) begin
            if (r.chk) chk("rd_blk0", req0_rd_blk, r.rblk);
            chk("idle_blk1", req1_rd_blk, BW'(0));
          end else begin
            if (r.chk) chk("rd_blk1", req1_rd_blk, r.rblk);
            chk("idle_blk0", req0_rd_blk, BW'(0));
          end
        end
      end else begin
        chk("quiet_outputs",
            BW'({req1_err, req0_err}) | req0_rd_blk | req1_rd_blk, BW'(0));
      end
    end
  end

  // Reference model: round-robin order over the batch, one access per job
  task automatic plan();
    int i0 = 0, i1 = 0, w, lat;
    bit p0, p1;
    job_t jb;
    while (i0 < b0.size() || i1 < b1.size()) begin
      p0 = i0 < b0.size();
      p1 = i1 < b1.size();
      w = (p0 && p1) ? 1 - model_last : (p1 ? 1 : 0);
      model_last = w;
      if (w != 0) begin
        jb = b1[i1];
        i1++;
      end else begin
        jb = b0[i0];
        i0++;
      end
      if (force_lat.size() != 0) lat = force_lat.pop_front();
      else if ($urandom_range(0, 5) == 0) lat = -1;
      else lat = $urandom_range(0, 6);
      exp_acc.push_back('{wr: jb.wr, addr: jb.addr, wblk: jb.blk, lat: lat});
      lat_q.push_back(lat);
      exp_rsp.push_back('{who: w, err: (lat < 0), chk: !jb.wr,
                          rblk: (lat < 0) ? BW'(0) : mem_data(jb.addr)});
    end
  endtask

  task automatic launch();
    @(posedge clk);
    #1;
    jobs0 = b0;
    jobs1 = b1;
    start_cnt++;
  endtask

  task automatic finish_wait();
    int c = 0;
    while ((exp_rsp.size() != 0 || jobs0.size() != 0 || jobs1.size() != 0)
           && c < 3000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("batch_timeout", BW'(exp_rsp.size() + jobs0.size() + jobs1.size()),
        BW'(0));
    if (c >= 3000) begin
      exp_rsp.delete();
      exp_acc.delete();
      lat_q.delete();
      jobs0.delete();
      jobs1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_batch();
    plan();
    launch();
    finish_wait();
    b0.delete();
    b1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    job_t jb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", BW'({req0_done, req1_done, req0_err, req1_err,
                           mem_rd_en, mem_wr_en, mem_addr}), BW'(0));
    chk("reset_blk", req0_rd_blk | req1_rd_blk | mem_wr_blk, BW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctrl", BW'({req0_done, req1_done, req0_err, req1_err,
                            mem_rd_en, mem_wr_en, mem_addr}), BW'(0));
    end

    // single refill, ack on the fourth strobe cycle
    b0.push_back(mk_job(0, 0, 32'h0000_1000));
    force_lat.push_back(3);
    plan();
    launch();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!mem_rd_en && n < 20);
    chk("grant_latency", BW'(n), BW'(2));
    finish_wait();
    b0.delete();

    // contention: alternating grants, writes only from requester 1
    for (int i = 0; i < 3; i++) begin
      b0.push_back(mk_job(0, 0, 32'h0000_2000 + 32'(i * 64)));
      b1.push_back(mk_job(1, 2, 32'h8000_3000 + 32'(i * 64)));
    end
    run_batch();

    // rd and wr together: write only, done once
    b1.push_back(mk_job(1, 3, 32'h0000_0040));
    run_batch();

    // timeout then a normal transaction
    b0.push_back(mk_job(0, 0, 32'h0000_5000));
    b0.push_back(mk_job(0, 0, 32'h0000_5040));
    force_lat.push_back(-1);
    force_lat.push_back(2);
    run_batch();

    // reset during an access, stray ack afterwards
    jb = mk_job(0, 0, 32'h0000_6000);
    exp_acc.push_back('{wr: 1'b0, addr: jb.addr, wblk: jb.blk, lat: -1});
    lat_q.push_back(-1);
    b0.push_back(jb);
    launch();
    b0.delete();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!mem_rd_en && n < 20);
    chk("abort_strobe_seen", BW'(mem_rd_en), BW'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    jobs0.delete();
    start_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    inject_cnt++;
    @(negedge clk);
    chk("abort_outputs", BW'({mem_rd_en, mem_wr_en, req0_done, req1_done,
                              req0_err, req1_err}), BW'(0));
    model_last = 1;
    lat_q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("abort_after_ack", BW'({mem_rd_en, mem_wr_en, req0_done,
                                req1_done}), BW'(0));
    b0.push_back(rnd_job(0));
    b1.push_back(rnd_job(1));
    run_batch();

    // randomized batches
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) b0.push_back(rnd_job(0));
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) b1.push_back(rnd_job(1));
      run_batch();
    end

    chk("acc_queue_empty", BW'(exp_acc.size()), BW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
